dma_copy: RTL and testbench

- Word-granular memory-to-memory copy engine.
- Acts as a second bus initiator on the same single-strobe bus the cpu drives: stb_o/we_o/adr_o/sel_o/dat_o out, dat_i/ack_i in.
- Software-facing side is a plain start/parameter port. A later bus-register wrapper or arbiter connects it to the cpu.
- Typical use: moving firmware images between bank 0x00 RAM regions, or streaming words into bank 0x01 peripherals.

---
 rtl/dma_copy.sv | 125 ++++++++++++
 tb/tb_dma_copy.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dma_copy.sv
// dma_copy: word-granular memory-to-memory copy engine acting as a single-strobe bus initiator
module dma_copy #(
   parameter int LEN_W    = 16,
   parameter int READ_LAT = 1
) (
   input  logic             clk,
   input  logic             rst_i,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic             stb_o,
   output logic             we_o,
   output logic [31:0]      adr_o,
   output logic [3:0]       sel_o,
   output logic [31:0]      dat_o,
   input  logic [31:0]      dat_i,
   input  logic             ack_i
);
   typedef enum logic [2:0] {S_IDLE, S_RD, S_RDLAT, S_WR, S_DONE} state_t;

   localparam logic [1:0] LAT_INIT = 2'(READ_LAT > 0 ? READ_LAT - 1 : 0);

   state_t           r_state, w_state;
   logic [31:0]      r_src, w_src, r_dst, w_dst, r_data, w_data, r_adr;
   logic [LEN_W-1:0] r_cnt, w_cnt;
   logic [1:0]       r_lat, w_lat;
   logic             r_abt, w_abt, r_stb, r_we, r_busy, r_done;

   always_comb begin
      w_state = r_state;
      w_src   = r_src;
      w_dst   = r_dst;
      w_cnt   = r_cnt;
      w_data  = r_data;
      w_lat   = r_lat;
      w_abt   = 1'b0;
      case (r_state)
         S_IDLE:
            if (start) begin
               if (len == '0)
                  w_state = S_DONE;
               else begin
                  w_state = S_RD;
                  w_src   = {src_addr[31:2], 2'b00};
                  w_dst   = {dst_addr[31:2], 2'b00};
                  w_cnt   = len;
               end
            end
         S_RD:
            if (ack_i) begin
               if (READ_LAT == 0) begin
                  w_data  = dat_i;
                  w_state = S_WR;
               end else begin
                  w_lat   = LAT_INIT;
                  w_state = S_RDLAT;
               end
            end
         S_RDLAT:
            if (r_lat == 2'd0) begin
               w_data  = dat_i;
               w_state = S_WR;
            end else
               w_lat = r_lat - 2'd1;
         S_WR:
            if (ack_i) begin
               w_src   = r_src + 32'd4;
               w_dst   = r_dst + 32'd4;
               w_cnt   = r_cnt - LEN_W'(1);
               // abort only counts as the cause when words were still left
               w_abt   = abort && (r_cnt != LEN_W'(1));
               w_state = (r_cnt == LEN_W'(1) || abort) ? S_DONE : S_RD;
            end
         S_DONE:
            w_state = S_IDLE;
         default:
            w_state = S_IDLE;
      endcase
   end

   // outputs are registered from the next state so they line up with the state they describe
   always_ff @(posedge clk) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_src   <= '0;
         r_dst   <= '0;
         r_cnt   <= '0;
         r_data  <= '0;
         r_lat   <= '0;
         r_abt   <= 1'b0;
         r_stb   <= 1'b0;
         r_we    <= 1'b0;
         r_adr   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_src   <= w_src;
         r_dst   <= w_dst;
         r_cnt   <= w_cnt;
         r_data  <= w_data;
         r_lat   <= w_lat;
         r_abt   <= w_abt;
         r_stb   <= (w_state == S_RD) || (w_state == S_WR);
         r_we    <= w_state == S_WR;
         r_adr   <= (w_state == S_WR) ? w_dst : w_src;
         r_busy  <= w_state != S_IDLE;
         r_done  <= w_state == S_DONE;
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign aborted = r_abt;
   assign stb_o   = r_stb;
   assign we_o    = r_we;
   assign adr_o   = r_adr;
   assign sel_o   = {4{r_stb}};
   assign dat_o   = r_data;
endmodule

// File: tb/tb_dma_copy.sv
// tb_dma_copy: directed checks of dma_copy against a word memory responder with registered read data
module tb_dma_copy;
   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        start = 1'b0;
   logic [31:0] src_addr = '0;
   logic [31:0] dst_addr = '0;
   logic [15:0] len = '0;
   logic        abort = 1'b0;
   logic        busy, done, aborted, stb_o, we_o, ack_i;
   logic [31:0] adr_o, dat_o;
   logic [31:0] dat_i = '0;
   logic [3:0]  sel_o;

   dma_copy dut (
      .clk(clk), .rst_i(rst_i), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
      .len(len), .abort(abort), .busy(busy), .done(done), .aborted(aborted),
      .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .sel_o(sel_o), .dat_o(dat_o),
      .dat_i(dat_i), .ack_i(ack_i)
   );

   always #5 clk = ~clk;

   logic [31:0] rmem [0:1023];
   logic [31:0] wmem [0:1023];
   logic [31:0] rd_log [0:7];
   logic [2:0]  wait_n = 3'd0;
   logic [2:0]  wcnt = 3'd0;
   int          n_acc = 0, n_rd = 0, n_wr = 0;
   int          n_stbcyc = 0, n_busy_nodone = 0, n_unstable = 0, n_badsel = 0;
   logic        p_wait = 1'b0, p_we = 1'b0;
   logic [31:0] p_adr = '0;

   assign ack_i = stb_o && (wcnt == wait_n);

   always @(posedge clk) begin
      if (stb_o && ack_i) begin
         wcnt  <= 3'd0;
         n_acc <= n_acc + 1;
         if (we_o) begin
            wmem[adr_o[11:2]] <= dat_o;
            n_wr <= n_wr + 1;
         end else begin
            dat_i <= rmem[adr_o[11:2]];
            rd_log[n_rd[2:0]] <= adr_o;
            n_rd <= n_rd + 1;
         end
      end else if (stb_o)
         wcnt <= wcnt + 3'd1;
   end

   always @(negedge clk) begin
      if (stb_o && sel_o !== 4'hF) n_badsel <= n_badsel + 1;
      if (!stb_o && sel_o !== 4'h0) n_badsel <= n_badsel + 1;
      if (p_wait && !rst_i && (!stb_o || adr_o !== p_adr || we_o !== p_we)) n_unstable <= n_unstable + 1;
      if (stb_o) n_stbcyc <= n_stbcyc + 1;
      if (busy && !done) n_busy_nodone <= n_busy_nodone + 1;
      p_wait <= stb_o && !ack_i;
      p_adr  <= adr_o;
      p_we   <= we_o;
   end

   int n_vec = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
      @(negedge clk);
      src_addr = s;
      dst_addr = d;
      len = n;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output logic ab);
      cyc = 1;
      while (!done && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      ab = aborted;
      if (!done) chk("done_timeout", 32'd0, 32'd1);
      @(negedge clk);
      chk("post_done_pulse", {31'd0, done}, 32'd0);
      chk("post_done_busy", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int cyc, s0, s1, s2, s3, k;
      logic ab;
      for (int i = 0; i < 1024; i++) rmem[i] = 32'h0BAD_0000 | i;
      rmem[0] = 32'h1111_1111;
      rmem[1] = 32'h2222_2222;
      rmem[2] = 32'h3333_3333;
      rmem[8] = 32'hA5A5_0001;
      rmem[9] = 32'h5A5A_0002;
      for (int i = 0; i < 8; i++) rmem[16 + i] = 32'h1000_0000 + i;
      rmem[1023] = 32'hCAFE_F00D;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_stb", {31'd0, stb_o}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_adr", adr_o, 32'd0);
      chk("rst_dat", dat_o, 32'd0);
      chk("rst_sel", {28'd0, sel_o}, 32'd0);
      @(negedge clk);
      rst_i = 1'b0;

      // basic three-word copy, ack in the strobe cycle
      s0 = n_acc;
      start_copy(32'h0000_0000, 32'h0000_0100, 16'd3);
      wait_done(cyc, ab);
      chk("basic_latency_9_10", {31'd0, (cyc >= 9 && cyc <= 10)}, 32'd1);
      chk("basic_aborted", {31'd0, ab}, 32'd0);
      chk("basic_strobes", n_acc - s0, 32'd6);
      chk("basic_w0", wmem[64], 32'h1111_1111);
      chk("basic_w1", wmem[65], 32'h2222_2222);
      chk("basic_w2", wmem[66], 32'h3333_3333);

      // zero length: no bus activity, only the DONE cycle is busy
      s0 = n_stbcyc; s1 = n_busy_nodone; s2 = n_acc;
      start_copy(32'h0000_0040, 32'h0000_0500, 16'd0);
      wait_done(cyc, ab);
      chk("zero_done_cycle", cyc, 32'd1);
      chk("zero_aborted", {31'd0, ab}, 32'd0);
      chk("zero_no_stb", n_stbcyc - s0, 32'd0);
      chk("zero_busy_only_done", n_busy_nodone - s1, 32'd0);
      chk("zero_no_acc", n_acc - s2, 32'd0);

      // three wait states on every access
      wait_n = 3'd3;
      s0 = n_stbcyc; s1 = n_unstable;
      start_copy(32'h0000_0020, 32'h0000_0300, 16'd2);
      wait_done(cyc, ab);
      wait_n = 3'd0;
      chk("wait_stb_cycles", n_stbcyc - s0, 32'd16);
      chk("wait_stable", n_unstable - s1, 32'd0);
      chk("wait_w0", wmem[192], 32'hA5A5_0001);
      chk("wait_w1", wmem[193], 32'h5A5A_0002);

      // abort raised during the third word's read
      s0 = n_rd; s1 = n_wr;
      start_copy(32'h0000_0040, 32'h0000_0400, 16'd8);
      k = 0;
      while (!((n_rd - s0) == 2 && stb_o && !we_o) && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("abort_reach_rd3", {31'd0, k < 100}, 32'd1);
      abort = 1'b1;
      wait_done(cyc, ab);
      abort = 1'b0;
      chk("abort_flag", {31'd0, ab}, 32'd1);
      chk("abort_reads", n_rd - s0, 32'd3);
      chk("abort_writes", n_wr - s1, 32'd3);
      chk("abort_w0", wmem[256], 32'h1000_0000);
      chk("abort_w2", wmem[258], 32'h1000_0002);

      // unaligned source that wraps through zero
      s0 = n_rd;
      start_copy(32'hFFFF_FFFE, 32'h0000_0600, 16'd2);
      wait_done(cyc, ab);
      s2 = s0 % 8; s3 = (s0 + 1) % 8;
      chk("wrap_rd0_adr", rd_log[s2], 32'hFFFF_FFFC);
      chk("wrap_rd1_adr", rd_log[s3], 32'h0000_0000);
      chk("wrap_w0", wmem[384], 32'hCAFE_F00D);
      chk("wrap_w1", wmem[385], 32'h1111_1111);

      // reset while a write strobe is up
      start_copy(32'h0000_0000, 32'h0000_0700, 16'd3);
      k = 0;
      while (!(stb_o && we_o) && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("rstmid_reach_wr", {31'd0, k < 100}, 32'd1);
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      chk("rstmid_stb", {31'd0, stb_o}, 32'd0);
      chk("rstmid_busy", {31'd0, busy}, 32'd0);
      chk("rstmid_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst_i = 1'b0;
      start_copy(32'h0000_0020, 32'h0000_0800, 16'd1);
      wait_done(cyc, ab);
      chk("rstmid_after_w", wmem[512], 32'hA5A5_0001);
      chk("rstmid_after_ab", {31'd0, ab}, 32'd0);

      chk("sel_lanes", n_badsel, 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
